// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Instruction fetch stage of the Mini-MIPS core. Holds the word-addressed
// instruction memory and the program counter. While idle, an external loader
// writes the program. Once running, the stage presents one registered
// instruction per cycle, together with its PC, to the decode stage. It honours
// a downstream stall and a branch/jump redirect, and traps any fetch from an
// index outside the memory.
//
// Parameters
//   IMEM_DEPTH  number of 32-bit instruction words
//   ADDR_W      loader address width (2**ADDR_W >= IMEM_DEPTH)
//   RESET_PC    word index where fetch starts after reset
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous active-low reset
//   load_en         loader write strobe (honoured only in IDLE)
//   load_addr       loader word index
//   load_data       loader instruction word
//   run             start / continue fetching
//   stall           decode not ready: hold all fetch outputs
//   redirect_valid  branch/jump taken
//   redirect_pc     redirect target word index
//   instr_valid     instr / instr_pc hold a live instruction
//   instr           fetched instruction word
//   instr_pc        word index of instr
//   pc              next word index to fetch
//   fault           sticky out-of-range fetch flag
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          ADDR_W     = 6,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic [31:0]       pc,
  output logic              fault
);

  localparam int          IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        fault_q;

  logic [31:0] imem [IMEM_DEPTH];

  // Range checks are done at full width so that out-of-range loader addresses
  // and wrapped/redirected PCs never alias onto a valid word.
  logic             load_in_range;
  logic             pc_in_range;
  logic [IDX_W-1:0] load_idx;
  logic [IDX_W-1:0] fetch_idx;

  assign load_in_range = 32'(load_addr) < DEPTH;
  assign pc_in_range   = pc_q < DEPTH;
  assign load_idx      = load_addr[IDX_W-1:0];
  assign fetch_idx     = pc_q[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Instruction memory write port (loader, IDLE only).
  // NOTE: the memory array has no reset so it maps onto RAM; the program image
  // survives reset and only the loader changes it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_en && (state_q == S_IDLE) && load_in_range) begin
      imem[load_idx] <= load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. The memory read is the synchronous
  // read into instr_q, so fetch latency from pc to instr is one edge.
  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values of pc_q/state_q, exactly like the flops they model.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          instr_valid_q <= 1'b0;
          if (run) begin
            state_q <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (redirect_valid) begin
            // One-bubble flush; takes priority over stall.
            pc_q          <= redirect_pc;
            instr_valid_q <= 1'b0;
          end else if (stall) begin
            // Hold everything so the presented instruction is neither lost
            // nor duplicated.
          end else if (!run) begin
            state_q       <= S_IDLE;
            instr_valid_q <= 1'b0;
          end else if (!pc_in_range) begin
            state_q       <= S_FAULT;
            fault_q       <= 1'b1;
            instr_valid_q <= 1'b0;
          end else begin
            instr_q       <= imem[fetch_idx];
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_q + 32'd1;
          end
        end

        S_FAULT: begin
          // Terminal until reset; pc keeps the faulting index.
          instr_valid_q <= 1'b0;
          fault_q       <= 1'b1;
        end

        default: begin
          state_q       <= S_IDLE;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Directed self-checking bench for instr_fetch_stage, built with a 4-word
// memory and a 3-bit loader address so that dropped out-of-range loader writes
// and the fetch fault are both reachable.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [2:0]  load_addr;
  logic [31:0] load_data;
  logic        run;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        fault;

  int errors = 0;
  int checks = 0;

  instr_fetch_stage #(
    .IMEM_DEPTH (4),
    .ADDR_W     (3),
    .RESET_PC   (32'd0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .run            (run),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc             (pc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v,
                            input logic [31:0] i, input logic [31:0] ipc,
                            input logic [31:0] p);
    check({tag, ".valid"}, 32'(instr_valid), 32'(v));
    if (v) begin
      check({tag, ".instr"}, instr, i);
      check({tag, ".instr_pc"}, instr_pc, ipc);
    end
    check({tag, ".pc"}, pc, p);
  endtask

  task automatic expect_reset_values(input string tag);
    check({tag, ".valid"}, 32'(instr_valid), 32'd0);
    check({tag, ".instr"}, instr, 32'd0);
    check({tag, ".instr_pc"}, instr_pc, 32'd0);
    check({tag, ".pc"}, pc, 32'd0);
    check({tag, ".fault"}, 32'(fault), 32'd0);
  endtask

  task automatic load_word(input logic [2:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    load_en        = 1'b0;
    load_addr      = '0;
    load_data      = '0;
    run            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values while reset is low.
    #2;
    expect_reset_values("por");
    reset = 1'b1;

    // Load the program; the write to index 4 is out of range and must drop
    // (if it aliased it would overwrite index 0).
    load_word(3'd0, 32'h11);
    load_word(3'd1, 32'h22);
    load_word(3'd2, 32'h33);
    load_word(3'd3, 32'h44);
    load_word(3'd4, 32'hDEAD_BEEF);
    expect_out("idle", 1'b0, 32'h0, 32'h0, 32'd0);

    // Start-up: edge 1 enters FETCH, edge 2 delivers the first word.
    run = 1'b1;
    tick();
    expect_out("start.e1", 1'b0, 32'h0, 32'h0, 32'd0);
    tick();
    expect_out("start.e2", 1'b1, 32'h11, 32'd0, 32'd1);
    tick();
    expect_out("seq1", 1'b1, 32'h22, 32'd1, 32'd2);

    // Stall three cycles while 0x22 is presented.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("stall", 1'b1, 32'h22, 32'd1, 32'd2);
    end
    stall = 1'b0;
    tick();
    expect_out("stall.release", 1'b1, 32'h33, 32'd2, 32'd3);

    // Redirect to 0 together with stall: redirect wins, one bubble.
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    stall          = 1'b1;
    tick();
    expect_out("redir.bubble", 1'b0, 32'h0, 32'h0, 32'd0);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    tick();
    expect_out("redir.target", 1'b1, 32'h11, 32'd0, 32'd1);
    tick();
    expect_out("redir.next", 1'b1, 32'h22, 32'd1, 32'd2);

    // Drop run, patch index 2, resume at the held pc.
    run = 1'b0;
    tick();
    expect_out("stop", 1'b0, 32'h0, 32'h0, 32'd2);
    load_word(3'd2, 32'h99);
    expect_out("patch", 1'b0, 32'h0, 32'h0, 32'd2);
    run = 1'b1;
    tick();
    expect_out("resume.e1", 1'b0, 32'h0, 32'h0, 32'd2);
    tick();
    expect_out("resume.e2", 1'b1, 32'h99, 32'd2, 32'd3);
    tick();
    expect_out("last", 1'b1, 32'h44, 32'd3, 32'd4);
    check("last.fault", 32'(fault), 32'd0);

    // Fetch at pc=4 faults.
    tick();
    expect_out("fault", 1'b0, 32'h0, 32'h0, 32'd4);
    check("fault.flag", 32'(fault), 32'd1);

    // Fault is sticky against run, redirect and loader writes.
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    load_en        = 1'b1;
    load_addr      = 3'd0;
    load_data      = 32'h55;
    for (int k = 0; k < 2; k++) begin
      tick();
      expect_out("fault.hold", 1'b0, 32'h0, 32'h0, 32'd4);
      check("fault.hold.flag", 32'(fault), 32'd1);
    end
    redirect_valid = 1'b0;
    load_en        = 1'b0;

    // Reset between edges clears everything at once.
    #2;
    reset = 1'b0;
    #1;
    expect_reset_values("rst.fault");
    run   = 1'b1;
    reset = 1'b1;
    tick();
    expect_out("restart.e1", 1'b0, 32'h0, 32'h0, 32'd0);
    tick();
    expect_out("restart.e2", 1'b1, 32'h11, 32'd0, 32'd1);
    tick();
    expect_out("restart.e3", 1'b1, 32'h22, 32'd1, 32'd2);

    // Reset mid-FETCH, then a loader write on the same edge as run.
    #2;
    reset = 1'b0;
    #1;
    expect_reset_values("rst.fetch");
    load_en   = 1'b1;
    load_addr = 3'd0;
    load_data = 32'h77;
    run       = 1'b1;
    reset     = 1'b1;
    tick();
    load_en = 1'b0;
    expect_out("ldrun.e1", 1'b0, 32'h0, 32'h0, 32'd0);
    tick();
    expect_out("ldrun.e2", 1'b1, 32'h77, 32'd0, 32'd1);
    tick();
    expect_out("ldrun.e3", 1'b1, 32'h22, 32'd1, 32'd2);
    tick();
    expect_out("ldrun.e4", 1'b1, 32'h99, 32'd2, 32'd3);
    tick();
    expect_out("ldrun.e5", 1'b1, 32'h44, 32'd3, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
